// File: rtl/mc_controller_ext.sv
// Multicycle MIPS-subset main controller: one state register plus decoded
// control outputs, with memory-ready stalls and an unsupported-instruction flag.
module mc_controller_ext #(
    parameter int ALUCTRL_W     = 3,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pcen,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic                 iord,
    output logic                 memtoreg,
    output logic                 regdst,
    output logic                 immsrc,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic [3:0]           state,
    output logic                 illegal
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
        BEQEX   = 4'd8,  ADDIEX  = 4'd9,  IMMWB  = 4'd10, JEX    = 4'd11,
        ANDIEX  = 4'd12, ORIEX   = 4'd13, BNEEX  = 4'd14
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_J = 6'b000010;

    state_t cur, nxt;
    logic   ready;
    logic   op_ok, funct_ok, bad_instr;
    logic   pcwrite;
    logic [2:0] alu3, funct_alu;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state = cur;

    always_comb begin
        op_ok = 1'b0;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_ok = 1'b1;
            default:                        op_ok = 1'b0;
        endcase
    end

    // funct_ok doubles as the legality test for R-type instructions
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    assign bad_instr = !op_ok || ((op == OP_R) && !funct_ok);

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = ready ? DECODE : FETCH;
            DECODE: begin
                if (bad_instr) nxt = FETCH;
                else begin
                    case (op)
                        OP_LW, OP_SW: nxt = MEMADR;
                        OP_R:         nxt = RTYPEEX;
                        OP_BEQ:       nxt = BEQEX;
                        OP_BNE:       nxt = BNEEX;
                        OP_ADDI:      nxt = ADDIEX;
                        OP_ANDI:      nxt = ANDIEX;
                        OP_ORI:       nxt = ORIEX;
                        default:      nxt = JEX;
                    endcase
                end
            end
            MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nxt = ready ? MEMWB : MEMRD;
            MEMWR:   nxt = ready ? FETCH : MEMWR;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX, ANDIEX, ORIEX: nxt = IMMWB;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        pcwrite  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        immsrc   = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        alu3     = 3'b010;
        illegal  = 1'b0;
        case (cur)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = ready;
                pcwrite = ready;
            end
            DECODE: begin
                alusrcb = 2'b11;
                illegal = bad_instr;
            end
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ANDIEX, ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                immsrc  = 1'b1;
                alu3    = (cur == ANDIEX) ? 3'b000 : 3'b001;
            end
            MEMRD:   iord = 1'b1;
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                alu3    = funct_alu;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            IMMWB:   regwrite = 1'b1;
            BEQEX, BNEEX: begin
                alusrca = 1'b1;
                pcsrc   = 2'b01;
                alu3    = 3'b110;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alucontrol      = '0;
        alucontrol[2:0] = alu3;
    end

    assign pcen = pcwrite | ((cur == BEQEX) & zero) | ((cur == BNEEX) & ~zero);

endmodule

// File: doc/mc_controller_ext.md
MC_CONTROLLER_EXT -- requirements
Module: mc_controller_ext

Interface
REQ-001 Parameter ALUCTRL_W, default 3: alucontrol width, SHALL be >=3; bits above [2:0] driven 0.
REQ-002 Parameter MEM_HANDSHAKE, default 1: 1 = honour mem_ready; 0 = mem_ready treated as constant 1.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-005 op / funct  input  6 / 6  instr[31:26] / instr[5:0].
REQ-006 zero  input  1  ALU zero flag; mem_ready  input  1  memory access complete this cycle.
REQ-007 pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, immsrc  output  1 each; immsrc=1 zero-extends immediate.
REQ-008 alusrcb / pcsrc  output  2 / 2; alucontrol  output  ALUCTRL_W.
REQ-009 state  output  4  current state code; illegal  output  1  one-cycle unsupported-instruction pulse.

Function
REQ-010 Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
REQ-011 Supported funct (R): add 100000, sub 100010, and 100100, or 100101, slt 101010.
REQ-012 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, IMMWB 10, JEX 11, ANDIEX 12, ORIEX 13, BNEEX 14; code 15 unused, SHALL go to FETCH.
REQ-013 Transitions: FETCH->DECODE on mem_ready, else hold; DECODE->MEMADR (lw/sw), RTYPEEX, BEQEX, BNEEX, ADDIEX, ANDIEX, ORIEX, JEX by opcode.
REQ-014 MEMADR->MEMRD (lw) / MEMWR (sw); MEMRD->MEMWB on mem_ready else hold; MEMWR->FETCH on mem_ready else hold.
REQ-015 MEMWB, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX -> FETCH; RTYPEEX->RTYPEWB; ADDIEX/ANDIEX/ORIEX->IMMWB.
REQ-016 DECODE with unsupported opcode, or R-type with unsupported funct: illegal=1 that cycle, next state FETCH, no write asserted.
REQ-017 All outputs not listed for a state SHALL be 0 (alusrcb/pcsrc 00).
REQ-018 FETCH: alusrcb=01, irwrite=mem_ready, pcwrite=mem_ready; DECODE: alusrcb=11.
REQ-019 MEMADR/ADDIEX: alusrca=1, alusrcb=10; ANDIEX/ORIEX: same plus immsrc=1.
REQ-020 MEMRD: iord=1; MEMWR: iord=1, memwrite=1 every cycle held; MEMWB: memtoreg=1, regwrite=1.
REQ-021 RTYPEEX: alusrca=1, alusrcb=00; RTYPEWB: regdst=1, regwrite=1; IMMWB: regwrite=1.
REQ-022 BEQEX/BNEEX: alusrca=1, pcsrc=01, ALU subtract; JEX: pcsrc=10, pcwrite=1.
REQ-023 pcen = pcwrite | (BEQEX & zero) | (BNEEX & ~zero), combinational.
REQ-024 alucontrol[2:0]: add 010, sub 110, and 000, or 001, slt 111; add in FETCH/DECODE/MEMADR/ADDIEX, sub in branch states, and in ANDIEX, or in ORIEX, funct-decoded in RTYPEEX, 010 elsewhere.
REQ-025 Latency with mem_ready=1: lw 5, sw 4, R/addi/andi/ori 4, beq/bne/j 3 cycles; each stalled cycle adds 1.

Reset
REQ-026 reset=1 at a rising edge SHALL force state=FETCH regardless of current state, including mid-stall.
REQ-027 While state=FETCH after reset, outputs per REQ-018; illegal=0; no register or memory write.

Verification
REQ-028 reset 2 cycles, op=001000 (0x20020005), mem_ready=1 -> states 0,1,9,10,0; regwrite=1 only in state 10.
REQ-029 instr 0x00e22025 (or) -> 0,1,6,7,0; alucontrol=001 in state 6; regdst=regwrite=1 in state 7.
REQ-030 instr 0x8c020050 (lw), mem_ready low 2 cycles in MEMRD -> state 3 held 3 cycles, iord=1 throughout, then 4 with memtoreg=regwrite=1.
REQ-031 beq (0x10000003) zero=1 -> pcen=1 in state 8; bne (0x14000003) zero=1 -> pcen=0 in state 14.
REQ-032 op=111111 -> illegal=1 in DECODE, next state 0, regwrite/memwrite never asserted.
REQ-033 sw (0xac670044) with mem_ready=0, reset asserted in MEMWR -> next state 0, memwrite=0.
